// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver files.
//   uart_state_e : receiver frame-sequencing states.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single-bit asynchronous input.
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous reset, active low (both flops load RST_VAL)
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk_i cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with centre sampling, framing-error and
// overflow reporting toward a ready/write FIFO interface.
// Ports:
//   clk_i     : system clock, rising edge
//   rst_i     : asynchronous reset, active low
//   rx_i      : serial line, idle high, asynchronous to clk_i
//   wr_rdy_i  : downstream FIFO can accept a word
//   wr_o      : one-cycle write strobe, data_o valid in the same cycle
//   data_o    : last successfully received word (LSb = first bit on the line)
//   frm_err_o : one-cycle pulse, a stop bit was sampled low
//   ovf_o     : one-cycle pulse, good frame dropped because wr_rdy_i was low
module uart_rx
  import uart_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  STOP_BITS = 1,
  parameter real CLK_HZ    = 160000000.0,
  parameter real BAUD_HZ   = 115200.0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  input  logic              wr_rdy_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              frm_err_o,
  output logic              ovf_o
);

  // int'() of a real rounds to nearest.
  localparam int BIT_CNT  = int'(CLK_HZ / BAUD_HZ);
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CNT_W    = $clog2(BIT_CNT + 1);
  localparam int IDX_W    = $clog2(DATA_W + STOP_BITS + 1);

  logic rx_sync;
  logic hist_q;
  logic [1:0] prime_q;
  logic armed_q;
  logic start_edge;
  logic expired;
  logic stop_err;

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic              frm_q, frm_d;
  logic              ovf_q, ovf_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_sync)
  );

  // The synchronizer and history flop come out of reset high, so a line that
  // is already low at release would look like a falling edge. prime_q waits
  // until the synchronizer carries real line data; armed_q then requires the
  // line to have been seen high before any edge is believed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist_q  <= 1'b1;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= rx_sync;
      prime_q <= {prime_q[0], 1'b1};
      armed_q <= armed_q | (prime_q[1] & rx_sync);
    end
  end

  assign start_edge = armed_q & hist_q & ~rx_sync;
  assign expired    = (cnt_q == '0);
  assign stop_err   = err_q | ~rx_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    err_d   = err_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    frm_d   = 1'b0;
    ovf_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          cnt_d   = CNT_W'(HALF_CNT - 1);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_sync) begin
          cnt_d   = CNT_W'(BIT_CNT - 1);
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE; // start bit gone by mid-bit: glitch
        end
      end
      ST_DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d = {rx_sync, shreg_q[DATA_W-1:1]};
          cnt_d   = CNT_W'(BIT_CNT - 1);
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q == IDX_W'(STOP_BITS - 1)) begin
          // Outputs are registered here, so they pulse in the first IDLE
          // cycle, while IDLE can already catch a back-to-back start edge.
          err_d   = stop_err;
          state_d = ST_IDLE;
          if (stop_err) begin
            frm_d = 1'b1;
          end else if (wr_rdy_i) begin
            wr_d   = 1'b1;
            data_d = shreg_q;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          err_d = stop_err;
          cnt_d = CNT_W'(BIT_CNT - 1);
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      frm_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      frm_q   <= frm_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_o      = wr_q;
  assign data_o    = data_q;
  assign frm_err_o = frm_q;
  assign ovf_o     = ovf_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed test of uart_rx at 16 clocks per bit (1.6 MHz / 100 kBd).
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       wr_rdy_i;
  logic       wr_o;
  logic [7:0] data_o;
  logic       frm_err_o;
  logic       ovf_o;

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the monitor processes).
  int         cyc = 0;
  int         wr_cnt = 0;
  int         frm_cnt = 0;
  int         ovf_cnt = 0;
  int         wr_cyc = 0;
  int         multi_hits = 0;
  logic [7:0] log_data [0:63];

  int wr0, frm0, ovf0, t0;

  uart_rx #(
    .DATA_W    (8),
    .STOP_BITS (1),
    .CLK_HZ    (1600000.0),
    .BAUD_HZ   (100000.0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .rx_i      (rx_i),
    .wr_rdy_i  (wr_rdy_i),
    .wr_o      (wr_o),
    .data_o    (data_o),
    .frm_err_o (frm_err_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_o) begin
      log_data[wr_cnt[5:0]] = data_o;
      wr_cnt++;
      wr_cyc = cyc;
    end
    if (frm_err_o) frm_cnt++;
    if (ovf_o) ovf_cnt++;
    if (int'(wr_o) + int'(frm_err_o) + int'(ovf_o) > 1) multi_hits++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input real bt);
    rx_i = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      #(bt);
    end
    rx_i = stop;
    #(bt);
  endtask

  task automatic snap();
    wr0  = wr_cnt;
    frm0 = frm_cnt;
    ovf0 = ovf_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_i    = 1'b0;
    rx_i     = 1'b1;
    wr_rdy_i = 1'b1;
    idle(4);
    check("rst_wr", 32'(wr_o), 32'd0);
    check("rst_frm", 32'(frm_err_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_data", 32'(data_o), 32'h00);
    rst_i = 1'b1;
    idle(10);

    // 0xA5, ready high, with latency bound from the start edge
    snap();
    @(negedge clk);
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 160.0);
    idle(40);
    check("a5_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("a5_data", 32'(data_o), 32'hA5);
    check("a5_latency_ok", 32'((wr_cyc - t0) <= 156), 32'd1);
    check("a5_frm", 32'(frm_cnt - frm0), 32'd0);

    // 3-clock low glitch on an idle line
    snap();
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(300);
    check("glitch_wr", 32'(wr_cnt - wr0), 32'd0);
    check("glitch_frm", 32'(frm_cnt - frm0), 32'd0);
    check("glitch_ovf", 32'(ovf_cnt - ovf0), 32'd0);

    // 0x3C with a low stop bit, then 0x5A
    snap();
    send_frame(8'h3C, 1'b0, 160.0);
    rx_i = 1'b1;
    idle(40);
    check("frm_err_count", 32'(frm_cnt - frm0), 32'd1);
    check("frm_wr", 32'(wr_cnt - wr0), 32'd0);
    check("frm_data_held", 32'(data_o), 32'hA5);
    snap();
    send_frame(8'h5A, 1'b1, 160.0);
    idle(40);
    check("5a_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("5a_data", 32'(data_o), 32'h5A);

    // 0x81 with the FIFO full
    snap();
    wr_rdy_i = 1'b0;
    send_frame(8'h81, 1'b1, 160.0);
    idle(40);
    wr_rdy_i = 1'b1;
    check("ovf_count", 32'(ovf_cnt - ovf0), 32'd1);
    check("ovf_wr", 32'(wr_cnt - wr0), 32'd0);
    check("ovf_data_held", 32'(data_o), 32'h5A);

    // back-to-back 0x00, 0xFF, 2% slow line
    snap();
    send_frame(8'h00, 1'b1, 163.2);
    send_frame(8'hFF, 1'b1, 163.2);
    idle(40);
    check("slow_wr_count", 32'(wr_cnt - wr0), 32'd2);
    check("slow_first", 32'(log_data[wr0[5:0]]), 32'h00);
    check("slow_second", 32'(log_data[6'(wr0 + 1)]), 32'hFF);

    // back-to-back 0x00, 0xFF, 2% fast line
    snap();
    send_frame(8'h00, 1'b1, 156.8);
    send_frame(8'hFF, 1'b1, 156.8);
    idle(40);
    check("fast_wr_count", 32'(wr_cnt - wr0), 32'd2);
    check("fast_first", 32'(log_data[wr0[5:0]]), 32'h00);
    check("fast_second", 32'(log_data[6'(wr0 + 1)]), 32'hFF);

    // break: line held low for many bit times gives exactly one framing error
    snap();
    send_frame(8'h00, 1'b0, 160.0);
    idle(480);
    rx_i = 1'b1;
    idle(40);
    check("break_frm", 32'(frm_cnt - frm0), 32'd1);
    check("break_wr", 32'(wr_cnt - wr0), 32'd0);

    // reset during the data bits of 0x55
    snap();
    rx_i = 1'b0;
    #160.0;
    for (int i = 0; i < 4; i++) begin
      rx_i = i[0];  // 0x55 LSb first: 1,0,1,0
      rx_i = ~rx_i;
      #160.0;
    end
    rst_i = 1'b0;
    idle(2);
    check("midrst_data", 32'(data_o), 32'h00);
    check("midrst_wr", 32'(wr_o), 32'd0);
    rx_i = 1'b1;
    idle(3);
    rst_i = 1'b1;
    idle(300);
    check("midrst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("midrst_no_frm", 32'(frm_cnt - frm0), 32'd0);

    // reset released while the line is already low
    snap();
    rst_i = 1'b0;
    rx_i  = 1'b0;
    idle(3);
    rst_i = 1'b1;
    idle(300);
    check("lowrel_wr", 32'(wr_cnt - wr0), 32'd0);
    check("lowrel_frm", 32'(frm_cnt - frm0), 32'd0);
    rx_i = 1'b1;
    idle(20);

    // 0x33 after the resets
    snap();
    send_frame(8'h33, 1'b1, 160.0);
    idle(40);
    check("33_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("33_data", 32'(data_o), 32'h33);

    check("one_hot_pulses", 32'(multi_hits), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx
